intr_ctrl: RTL and testbench

INTR_CTRL -- requirements
Module: intr_ctrl

---
 rtl/intr_ctrl_pkg.sv | 18 +
 rtl/intr_ctrl_if.sv | 21 ++
 rtl/intr_prio_enc.sv | 22 ++
 rtl/intr_ctrl.sv | 161 ++++++++++++++++
 tb/tb_intr_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding,
// the source-count ceiling and the default register addresses.
package intr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } intrState_t;

    // irqId is 3 bits wide, so the controller never handles more than 8 sources
    localparam int maxSrc = 8;

    localparam logic [31:0] defIenBase   = 32'hF000_0200;
    localparam logic [31:0] defIpndBase  = 32'hF000_0204;
    localparam logic [31:0] defIctrlBase = 32'hF000_0208;

endpackage

// File: rtl/intr_ctrl_if.sv
// CPU-side bus strobes and interrupt handshake of the interrupt controller.
// The data bus is a plain inout port on the controller and is not part of this interface.
interface intr_ctrl_if #(
    parameter int DBITS = 32
);
    logic             wrtEn;
    logic [DBITS-1:0] address;
    logic             irqAck;
    logic             irq;
    logic [2:0]       irqId;

    modport master (
        output wrtEn, address, irqAck,
        input  irq, irqId
    );

    modport slave (
        input  wrtEn, address, irqAck,
        output irq, irqId
    );
endinterface

// File: rtl/intr_prio_enc.sv
// Combinational priority encoder: reports the lowest set request bit and whether any bit is set.
module intr_prio_enc #(
    parameter int NSRC = 4
) (
    input  logic [NSRC-1:0] req,
    output logic            valid,
    output logic [2:0]      idx
);

    // Scanning from the top down lets the lowest set index overwrite the others
    always_comb begin
        valid = 1'b0;
        idx   = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: edge-detects level sources into a pending register, masks them
// with an enable register and runs an IDLE/REQ/SERV handshake with the CPU.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int               DBITS     = 32,
    parameter int               NSRC      = 4,
    parameter logic [DBITS-1:0] IENBASE   = DBITS'(defIenBase),
    parameter logic [DBITS-1:0] IPNDBASE  = DBITS'(defIpndBase),
    parameter logic [DBITS-1:0] ICTRLBASE = DBITS'(defIctrlBase)
) (
    input  logic            clk,
    input  logic            reset,
    intr_ctrl_if.slave      bus,
    inout  wire [DBITS-1:0] dbus,
    input  logic [NSRC-1:0] irqSrc
);

    intrState_t        state;
    intrState_t        stateNext;
    logic              irqQ;
    logic              irqNext;
    logic [2:0]        irqIdQ;
    logic [2:0]        irqIdNext;
    logic              ackClear;

    logic [NSRC-1:0]   ien;
    logic [NSRC-1:0]   pending;
    logic [NSRC-1:0]   srcQ;
    logic              primed;

    logic              hitIen;
    logic              hitIpnd;
    logic              hitCtrl;
    logic              wrIen;
    logic              wrIpnd;
    logic              eoi;

    logic [NSRC-1:0]   rise;
    logic [NSRC-1:0]   clrMask;
    logic [NSRC-1:0]   ackMask;
    logic [NSRC-1:0]   pendEff;
    logic [NSRC-1:0]   ienEff;
    logic [maxSrc-1:0] pendWide;
    logic [maxSrc-1:0] ienWide;
    logic [maxSrc-1:0] ackWide;
    logic              reqLive;

    logic              encValid;
    logic [2:0]        encIdx;
    logic [DBITS-1:0]  rdData;
    logic              unusedDbus;

    assign hitIen  = (bus.address == IENBASE);
    assign hitIpnd = (bus.address == IPNDBASE);
    assign hitCtrl = (bus.address == ICTRLBASE);
    assign wrIen   = bus.wrtEn && hitIen;
    assign wrIpnd  = bus.wrtEn && hitIpnd;
    assign eoi     = bus.wrtEn && hitCtrl;

    // Edges are ignored for the first cycle after reset so a source already held high is not mistaken for a new request
    assign rise    = primed ? (irqSrc & ~srcQ) : '0;
    assign clrMask = wrIpnd ? dbus[NSRC-1:0] : '0;
    assign ackWide = maxSrc'(1) << irqIdQ;
    assign ackMask = ackClear ? ackWide[NSRC-1:0] : '0;

    // The held request is judged against this cycle's clears and enable writes, so a cancel beats a simultaneous ack
    assign pendEff  = (pending & ~clrMask) | rise;
    assign ienEff   = wrIen ? dbus[NSRC-1:0] : ien;
    assign pendWide = maxSrc'(pendEff);
    assign ienWide  = maxSrc'(ienEff);
    assign reqLive  = pendWide[irqIdQ] & ienWide[irqIdQ];

    assign unusedDbus = ^dbus[DBITS-1:NSRC];

    intr_prio_enc #(
        .NSRC(NSRC)
    ) u_prioEnc (
        .req  (pending & ien),
        .valid(encValid),
        .idx  (encIdx)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            irqQ   <= 1'b0;
            irqIdQ <= 3'd0;
        end else begin
            state  <= stateNext;
            irqQ   <= irqNext;
            irqIdQ <= irqIdNext;
        end
    end

    // Unreachable encoding 3 falls into the default branch and behaves as IDLE
    always_comb begin
        stateNext = IDLE;
        irqNext   = 1'b0;
        irqIdNext = irqIdQ;
        ackClear  = 1'b0;
        case (state)
            REQ: begin
                if (!reqLive) begin
                    stateNext = IDLE;
                end else if (bus.irqAck) begin
                    stateNext = SERV;
                    ackClear  = 1'b1;
                end else begin
                    stateNext = REQ;
                    irqNext   = 1'b1;
                end
            end
            SERV: begin
                stateNext = eoi ? IDLE : SERV;
            end
            default: begin
                if (encValid) begin
                    stateNext = REQ;
                    irqNext   = 1'b1;
                    irqIdNext = encIdx;
                end
            end
        endcase
    end

    // New edges win over both software clears and the acknowledge clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            ien     <= '0;
            pending <= '0;
            srcQ    <= '0;
            primed  <= 1'b0;
        end else begin
            primed  <= 1'b1;
            srcQ    <= irqSrc;
            pending <= (pending & ~clrMask & ~ackMask) | rise;
            if (wrIen) begin
                ien <= dbus[NSRC-1:0];
            end
        end
    end

    always_comb begin
        rdData = '0;
        if (hitIen) begin
            rdData[NSRC-1:0] = ien;
        end else if (hitIpnd) begin
            rdData[NSRC-1:0] = pending;
        end else if (hitCtrl) begin
            rdData[5:4] = state;
            rdData[2:0] = irqIdQ;
        end
    end

    assign dbus = (!bus.wrtEn && (hitIen || hitIpnd || hitCtrl)) ? rdData : 'z;

    assign bus.irq   = irqQ;
    assign bus.irqId = irqIdQ;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed testbench for intr_ctrl: walks the handshake, priority, cancel, reset and bus-release cases.
module tb_intr_ctrl;

    localparam logic [31:0] ienAddr   = 32'hF000_0200;
    localparam logic [31:0] ipndAddr  = 32'hF000_0204;
    localparam logic [31:0] ctrlAddr  = 32'hF000_0208;
    localparam logic [31:0] unmapAddr = 32'hF000_020C;
    localparam logic [31:0] released  = 32'hFFFF_FFFF;

    logic        clk;
    logic        reset;
    logic [3:0]  irqSrc;
    logic [31:0] tbData;
    logic        tbDrv;
    logic [31:0] rd;
    wire  [31:0] dbus;
    int          nAsserts;
    int          nFails;

    intr_ctrl_if #(.DBITS(32)) bus ();

    // Weak pull-up makes a released bus read as all ones
    pullup (dbus);
    assign dbus = tbDrv ? tbData : 'z;

    intr_ctrl #(
        .DBITS(32),
        .NSRC (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .dbus  (dbus),
        .irqSrc(irqSrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] src, input logic ack);
        irqSrc     = src;
        bus.irqAck = ack;
        @(posedge clk);
        #1;
        bus.irqAck = 1'b0;
    endtask

    task automatic writeReg(input logic [31:0] addr, input logic [31:0] data);
        bus.wrtEn   = 1'b1;
        bus.address = addr;
        tbData      = data;
        tbDrv       = 1'b1;
        @(posedge clk);
        #1;
        bus.wrtEn   = 1'b0;
        tbDrv       = 1'b0;
        bus.address = '0;
    endtask

    task automatic readReg(input logic [31:0] addr, output logic [31:0] data);
        bus.wrtEn   = 1'b0;
        bus.address = addr;
        #1;
        data        = dbus;
        bus.address = '0;
    endtask

    initial begin
        nAsserts    = 0;
        nFails      = 0;
        reset       = 1'b0;
        irqSrc      = '0;
        tbData      = '0;
        tbDrv       = 1'b0;
        bus.wrtEn   = 1'b0;
        bus.address = '0;
        bus.irqAck  = 1'b0;

        // Reset wins over a bus write in the same cycle
        applyStimulus(4'b0000, 1'b0);
        writeReg(ienAddr, 32'h0000_000F);
        reset = 1'b1;
        checkOutput("resetIrq", 32'(bus.irq), 32'd0);
        checkOutput("resetIrqId", 32'(bus.irqId), 32'd0);
        readReg(ienAddr, rd);
        checkOutput("resetIen", rd, 32'h0);
        readReg(ipndAddr, rd);
        checkOutput("resetIpnd", rd, 32'h0);
        readReg(ctrlAddr, rd);
        checkOutput("resetCtrl", rd, 32'h0);

        $display("[TB] single source handshake");
        writeReg(ienAddr, 32'h0000_0001);
        applyStimulus(4'b0001, 1'b0);
        checkOutput("s1IrqAt1", 32'(bus.irq), 32'd0);
        applyStimulus(4'b0001, 1'b0);
        checkOutput("s1IrqAt2", 32'(bus.irq), 32'd1);
        checkOutput("s1IrqId", 32'(bus.irqId), 32'd0);
        readReg(ctrlAddr, rd);
        checkOutput("s1CtrlReq", rd, 32'h10);
        readReg(ipndAddr, rd);
        checkOutput("s1IpndReq", rd, 32'h1);
        applyStimulus(4'b0001, 1'b1);
        checkOutput("s1IrqServ", 32'(bus.irq), 32'd0);
        readReg(ipndAddr, rd);
        checkOutput("s1IpndServ", rd, 32'h0);
        readReg(ctrlAddr, rd);
        checkOutput("s1CtrlServ", rd, 32'h20);
        writeReg(ctrlAddr, 32'h0);
        readReg(ctrlAddr, rd);
        checkOutput("s1CtrlEoi", rd, 32'h0);
        applyStimulus(4'b0000, 1'b0);

        $display("[TB] priority between simultaneous sources");
        writeReg(ienAddr, 32'h0000_000F);
        applyStimulus(4'b1010, 1'b0);
        applyStimulus(4'b1010, 1'b0);
        checkOutput("s2Irq", 32'(bus.irq), 32'd1);
        checkOutput("s2IrqId", 32'(bus.irqId), 32'd1);
        applyStimulus(4'b1010, 1'b1);
        readReg(ipndAddr, rd);
        checkOutput("s2IpndServ", rd, 32'h8);
        writeReg(ctrlAddr, 32'h0);
        checkOutput("s2IrqAfterEoi", 32'(bus.irq), 32'd0);
        applyStimulus(4'b1010, 1'b0);
        checkOutput("s2Irq3", 32'(bus.irq), 32'd1);
        checkOutput("s2IrqId3", 32'(bus.irqId), 32'd3);
        applyStimulus(4'b1010, 1'b1);
        writeReg(ctrlAddr, 32'h0);
        applyStimulus(4'b0000, 1'b0);

        $display("[TB] cancel by pending clear beats ack");
        applyStimulus(4'b0100, 1'b0);
        applyStimulus(4'b0100, 1'b0);
        checkOutput("s3IrqId", 32'(bus.irqId), 32'd2);
        bus.irqAck = 1'b1;
        writeReg(ipndAddr, 32'h0000_0004);
        bus.irqAck = 1'b0;
        checkOutput("s3IrqCancel", 32'(bus.irq), 32'd0);
        readReg(ctrlAddr, rd);
        checkOutput("s3CtrlIdle", rd, 32'h02);
        readReg(ipndAddr, rd);
        checkOutput("s3IpndClr", rd, 32'h0);
        applyStimulus(4'b0100, 1'b0);
        checkOutput("s3NoRaise", 32'(bus.irq), 32'd0);
        applyStimulus(4'b0000, 1'b0);

        $display("[TB] set beats write-1-to-clear");
        writeReg(ienAddr, 32'h0);
        irqSrc = 4'b0001;
        writeReg(ipndAddr, 32'h0000_0001);
        readReg(ipndAddr, rd);
        checkOutput("s4SetWins", rd, 32'h1);
        writeReg(ipndAddr, 32'h0000_0001);
        readReg(ipndAddr, rd);
        checkOutput("s4Cleared", rd, 32'h0);

        $display("[TB] EOI outside SERV and reset mid-service");
        writeReg(ienAddr, 32'h0000_0002);
        applyStimulus(4'b0011, 1'b0);
        applyStimulus(4'b0011, 1'b0);
        checkOutput("s5IrqId", 32'(bus.irqId), 32'd1);
        writeReg(ctrlAddr, 32'h0);
        readReg(ctrlAddr, rd);
        checkOutput("s5EoiInReq", rd, 32'h11);
        checkOutput("s5IrqHeld", 32'(bus.irq), 32'd1);
        applyStimulus(4'b0011, 1'b1);
        readReg(ctrlAddr, rd);
        checkOutput("s5CtrlServ", rd, 32'h21);
        applyStimulus(4'b0111, 1'b0);
        readReg(ipndAddr, rd);
        checkOutput("s5IpndInServ", rd, 32'h4);
        checkOutput("s5NoNest", 32'(bus.irq), 32'd0);
        reset = 1'b0;
        applyStimulus(4'b0111, 1'b0);
        reset = 1'b1;
        checkOutput("s5RstIrq", 32'(bus.irq), 32'd0);
        checkOutput("s5RstIrqId", 32'(bus.irqId), 32'd0);
        readReg(ienAddr, rd);
        checkOutput("s5RstIen", rd, 32'h0);
        readReg(ipndAddr, rd);
        checkOutput("s5RstIpnd", rd, 32'h0);
        readReg(ctrlAddr, rd);
        checkOutput("s5RstCtrl", rd, 32'h0);
        writeReg(ienAddr, 32'h0000_000F);
        applyStimulus(4'b0111, 1'b0);
        applyStimulus(4'b0111, 1'b0);
        checkOutput("s5HeldNoIrq", 32'(bus.irq), 32'd0);
        readReg(ipndAddr, rd);
        checkOutput("s5HeldNoPend", rd, 32'h0);
        applyStimulus(4'b0101, 1'b0);
        applyStimulus(4'b0111, 1'b0);
        checkOutput("s5ToggleLat1", 32'(bus.irq), 32'd0);
        applyStimulus(4'b0111, 1'b0);
        checkOutput("s5ToggleIrq", 32'(bus.irq), 32'd1);
        checkOutput("s5ToggleId", 32'(bus.irqId), 32'd1);

        $display("[TB] bus release");
        readReg(unmapAddr, rd);
        checkOutput("s6Unmapped", rd, released);
        bus.wrtEn   = 1'b1;
        bus.address = ipndAddr;
        #1;
        rd          = dbus;
        bus.wrtEn   = 1'b0;
        bus.address = '0;
        checkOutput("s6WriteCycle", rd, released);
        readReg(ienAddr, rd);
        checkOutput("s6MappedRead", rd, 32'h0000_000F);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
